// File: rtl/round_controller.sv
// round_controller: game-round sequencer between the gameplay datapath and the
// top-level game-state FSM. Counts pellets and lives, times the ready/death
// pauses and the frightened window, and freezes or respawns the sprites.
//
// Optional feature: define ROUND_CTRL_EXTRA_LIFE_EN to award one bonus life when
// pellets_left reaches TOTAL_PELLETS - EXTRA_LIFE_PELLETS (once per game).
//
// Ports:
//   Clk, Reset        - clock, synchronous active-high reset
//   reseton           - synchronous clear from the top-level FSM (same as Reset)
//   frame_tick        - one pulse per video frame
//   pellet_eaten      - normal pellet consumed (pulse)
//   power_eaten       - power pellet consumed (pulse)
//   ghost_hit         - Pacman/ghost overlap (pulse)
//   freeze            - sprites must not move
//   respawn           - one-cycle pulse, sprites return home
//   frightened        - ghosts vulnerable
//   over, win         - held terminal indications
//   lives             - remaining lives
//   pellets_left      - pellets still on the maze
module round_controller #(
  parameter int unsigned TOTAL_PELLETS      = 244,
  parameter int unsigned START_LIVES        = 3,
  parameter int unsigned READY_FRAMES       = 120,
  parameter int unsigned DEATH_FRAMES       = 90,
  parameter int unsigned FRIGHT_FRAMES      = 360,
  parameter int unsigned EXTRA_LIFE_PELLETS = 100
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       reseton,
  input  logic       frame_tick,
  input  logic       pellet_eaten,
  input  logic       power_eaten,
  input  logic       ghost_hit,
  output logic       freeze,
  output logic       respawn,
  output logic       frightened,
  output logic       over,
  output logic       win,
  output logic [2:0] lives,
  output logic [8:0] pellets_left
);

  localparam int unsigned PAUSE_MAX = (READY_FRAMES > DEATH_FRAMES) ? READY_FRAMES : DEATH_FRAMES;
  localparam int unsigned FRAME_W   = ($clog2(PAUSE_MAX + 1) < 1) ? 1 : $clog2(PAUSE_MAX + 1);
  localparam int unsigned FRIGHT_W  = ($clog2(FRIGHT_FRAMES + 1) < 1) ? 1 : $clog2(FRIGHT_FRAMES + 1);

  // Elaboration-time sanity check of the configuration.
  if (START_LIVES < 1 || START_LIVES > 7 || TOTAL_PELLETS < 1 || TOTAL_PELLETS > 511 ||
      EXTRA_LIFE_PELLETS > TOTAL_PELLETS || READY_FRAMES < 1 || DEATH_FRAMES < 1) begin : g_bad_cfg
    $error("round_controller: parameter out of range");
  end

  typedef enum logic [2:0] {S_READY, S_PLAY, S_DYING, S_LOST, S_WON} state_t;

  state_t              state, state_next;
  logic [FRAME_W-1:0]  frame_cnt, cnt_next;
  logic [FRIGHT_W-1:0] fright, fright_next;
  logic [2:0]          lives_next;
  logic [8:0]          pel_next;
  logic                respawn_next;
  logic                ate;

`ifdef ROUND_CTRL_EXTRA_LIFE_EN
  localparam int unsigned BONUS_AT = TOTAL_PELLETS - EXTRA_LIFE_PELLETS;
  logic bonus_done, bonus_next;
`endif

  assign ate = pellet_eaten || power_eaten;

  // State and output registers; every output is derived from next-state values.
  always_ff @(posedge Clk) begin
    if (Reset || reseton) begin
      state        <= S_READY;
      frame_cnt    <= '0;
      fright       <= '0;
      lives        <= 3'(START_LIVES);
      pellets_left <= 9'(TOTAL_PELLETS);
      freeze       <= 1'b1;
      respawn      <= 1'b1;
      frightened   <= 1'b0;
      over         <= 1'b0;
      win          <= 1'b0;
`ifdef ROUND_CTRL_EXTRA_LIFE_EN
      bonus_done   <= 1'b0;
`endif
    end else begin
      state        <= state_next;
      frame_cnt    <= cnt_next;
      fright       <= fright_next;
      lives        <= lives_next;
      pellets_left <= pel_next;
      freeze       <= (state_next != S_PLAY);
      respawn      <= respawn_next;
      frightened   <= (state_next == S_PLAY) && (fright_next != '0);
      over         <= (state_next == S_LOST);
      win          <= (state_next == S_WON);
`ifdef ROUND_CTRL_EXTRA_LIFE_EN
      bonus_done   <= bonus_next;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_next   = state;
    cnt_next     = frame_cnt;
    fright_next  = fright;
    lives_next   = lives;
    pel_next     = pellets_left;
    respawn_next = 1'b0;
`ifdef ROUND_CTRL_EXTRA_LIFE_EN
    bonus_next   = bonus_done;
`endif
    case (state)
      S_READY: begin
        if (frame_tick) begin
          if (frame_cnt == FRAME_W'(READY_FRAMES - 1)) begin
            cnt_next   = '0;
            state_next = S_PLAY;
          end else begin
            cnt_next = frame_cnt + FRAME_W'(1);
          end
        end
      end
      S_PLAY: begin
        // A power pellet reloads the window even if it is already running.
        if (power_eaten) begin
          fright_next = FRIGHT_W'(FRIGHT_FRAMES);
        end else if (frame_tick && fright != '0) begin
          fright_next = fright - FRIGHT_W'(1);
        end
        if (ate && pellets_left != '0) begin
          pel_next = pellets_left - 9'd1;
`ifdef ROUND_CTRL_EXTRA_LIFE_EN
          if (!bonus_done && pel_next == 9'(BONUS_AT)) begin
            bonus_next = 1'b1;
            if (lives != 3'd7) lives_next = lives + 3'd1;
          end
`endif
        end
        // Last pellet beats a same-cycle hit; the hit uses the pre-update window.
        if (ate && pellets_left == 9'd1) begin
          state_next  = S_WON;
          fright_next = '0;
        end else if (ghost_hit && fright == '0) begin
          state_next  = S_DYING;
          fright_next = '0;
          cnt_next    = '0;
        end
      end
      S_DYING: begin
        if (frame_tick) begin
          if (frame_cnt == FRAME_W'(DEATH_FRAMES - 1)) begin
            cnt_next = '0;
            if (lives <= 3'd1) begin
              lives_next = 3'd0;
              state_next = S_LOST;
            end else begin
              lives_next   = lives - 3'd1;
              respawn_next = 1'b1;
              state_next   = S_READY;
            end
          end else begin
            cnt_next = frame_cnt + FRAME_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_round_controller.sv
// tb_round_controller: randomized, self-checking bench for round_controller.
// A behavioural model (remaining-tick countdowns, plain integers) predicts every
// output each cycle; directed phases add hand-computed literal expectations.
module tb_round_controller;

  localparam int TOTAL   = 244;
  localparam int LIVES0  = 3;
  localparam int RDY     = 120;
  localparam int DTH     = 90;
  localparam int FRT     = 360;
  localparam int XTRA    = 100;

  localparam int M_READY = 0;
  localparam int M_PLAY  = 1;
  localparam int M_DYING = 2;
  localparam int M_LOST  = 3;
  localparam int M_WON   = 4;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       reseton = 1'b0;
  logic       frame_tick = 1'b0;
  logic       pellet_eaten = 1'b0;
  logic       power_eaten = 1'b0;
  logic       ghost_hit = 1'b0;
  logic       freeze, respawn, frightened, over, win;
  logic [2:0] lives;
  logic [8:0] pellets_left;

  int n_checks = 0;
  int n_fail   = 0;

  round_controller dut (
    .Clk(Clk), .Reset(Reset), .reseton(reseton), .frame_tick(frame_tick),
    .pellet_eaten(pellet_eaten), .power_eaten(power_eaten), .ghost_hit(ghost_hit),
    .freeze(freeze), .respawn(respawn), .frightened(frightened), .over(over),
    .win(win), .lives(lives), .pellets_left(pellets_left)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode plus ticks-remaining counters.
  int m_mode, m_lives, m_pel, m_pause, m_fright;
  bit m_respawn, m_bonus, m_valid = 1'b0, m_hit_ok, m_ate;

  always @(posedge Clk) begin
    if (Reset || reseton) begin
      m_mode = M_READY; m_lives = LIVES0; m_pel = TOTAL; m_pause = RDY;
      m_fright = 0; m_respawn = 1'b1; m_bonus = 1'b0; m_valid = 1'b1;
    end else if (m_valid) begin
      m_respawn = 1'b0;
      if (m_mode == M_READY) begin
        if (frame_tick) begin
          m_pause = m_pause - 1;
          if (m_pause == 0) m_mode = M_PLAY;
        end
      end else if (m_mode == M_PLAY) begin
        m_hit_ok = ghost_hit && (m_fright == 0);
        m_ate    = pellet_eaten || power_eaten;
        if (m_ate && m_pel > 0) begin
          m_pel = m_pel - 1;
`ifdef ROUND_CTRL_EXTRA_LIFE_EN
          if (!m_bonus && m_pel == TOTAL - XTRA) begin
            m_bonus = 1'b1;
            m_lives = (m_lives + 1 > 7) ? 7 : m_lives + 1;
          end
`endif
        end
        if (power_eaten) m_fright = FRT;
        else if (frame_tick && m_fright > 0) m_fright = m_fright - 1;
        if (m_ate && m_pel == 0) begin
          m_mode = M_WON; m_fright = 0;
        end else if (m_hit_ok) begin
          m_mode = M_DYING; m_pause = DTH; m_fright = 0;
        end
      end else if (m_mode == M_DYING) begin
        if (frame_tick) begin
          m_pause = m_pause - 1;
          if (m_pause == 0) begin
            if (m_lives == 1) begin
              m_lives = 0; m_mode = M_LOST;
            end else begin
              m_lives = m_lives - 1; m_respawn = 1'b1;
              m_mode = M_READY; m_pause = RDY;
            end
          end
        end
      end
    end
    #1;
    if (m_valid) begin
      chk("freeze",       32'(freeze),       32'(m_mode != M_PLAY));
      chk("respawn",      32'(respawn),      32'(m_respawn));
      chk("frightened",   32'(frightened),   32'((m_mode == M_PLAY) && (m_fright > 0)));
      chk("over",         32'(over),         32'(m_mode == M_LOST));
      chk("win",          32'(win),          32'(m_mode == M_WON));
      chk("lives",        32'(lives),        32'(m_lives));
      chk("pellets_left", 32'(pellets_left), 32'(m_pel));
    end
  end

  // Apply one cycle of inputs, return at the following negedge.
  task automatic step(input bit ft, input bit pe, input bit pw, input bit gh, input bit rs);
    frame_tick = ft; pellet_eaten = pe; power_eaten = pw; ghost_hit = gh; reseton = rs;
    @(negedge Clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Run through a READY pause with random (ignored) events, bounded.
  task automatic pass_ready();
    int k = 0;
    while (freeze && k < 1000) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'b0);
      k++;
    end
    idle();
    chk("ready_exit", 32'(freeze), 32'd0);
  endtask

  int cnt;
  int exp_lives_win;

  initial begin
    // Reset and first READY pause.
    @(negedge Clk);
    @(negedge Clk);
    chk("rst_respawn", 32'(respawn), 32'd1);
    chk("rst_freeze",  32'(freeze),  32'd1);
    chk("rst_lives",   32'(lives),   32'd3);
    chk("rst_pellets", 32'(pellets_left), 32'd244);
    chk("rst_over",    32'(over),    32'd0);
    Reset = 1'b0;
    for (int i = 0; i < RDY - 1; i++)
      step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), 1'b0);
    chk("ready_119", 32'(freeze), 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ready_120", 32'(freeze), 32'd0);

    // Eat every pellet, last one coinciding with a ghost hit.
    for (int i = 0; i < TOTAL - 1; i++)
      step(1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 7) == 0), 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
`ifdef ROUND_CTRL_EXTRA_LIFE_EN
    exp_lives_win = 4;
`else
    exp_lives_win = 3;
`endif
    chk("win_win",    32'(win),    32'd1);
    chk("win_over",   32'(over),   32'd0);
    chk("win_lives",  32'(lives),  32'(exp_lives_win));
    chk("win_freeze", 32'(freeze), 32'd1);
    repeat (5) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("win_held", 32'(win), 32'd1);

    // Three unfrightened deaths.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("clr_pellets", 32'(pellets_left), 32'd244);
    chk("clr_win",     32'(win),          32'd0);
    pass_ready();
    for (int d = 0; d < 3; d++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("hit_freeze", 32'(freeze), 32'd1);
      for (int i = 0; i < DTH - 1; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("dying_hold", 32'(freeze), 32'd1);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("death_lives", 32'(lives), 32'(2 - d));
      if (d < 2) begin
        chk("death_respawn", 32'(respawn), 32'd1);
        pass_ready();
      end else begin
        chk("death_over", 32'(over), 32'd1);
      end
    end
    repeat (5) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("over_held", 32'(over), 32'd1);

    // Power pellet, retrigger after 200 ticks, ghost hit inside the window.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    pass_ready();
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("fright_on", 32'(frightened), 32'd1);
    for (int i = 0; i < 200; i++) step(1'b1, 1'b0, 1'b0, 1'(i == 50), 1'b0);
    chk("fright_mid",  32'(frightened), 32'd1);
    chk("fright_hit_lives", 32'(lives), 32'd3);
    chk("fright_hit_play",  32'(freeze), 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cnt = 0;
    while (frightened && cnt < 1000) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cnt++;
    end
    chk("fright_total", 32'(200 + cnt), 32'd560);

    // reseton in the middle of the death pause.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (30) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mid_dying", 32'(freeze), 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rson_lives",   32'(lives),        32'd3);
    chk("rson_pellets", 32'(pellets_left), 32'd244);
    chk("rson_over",    32'(over),         32'd0);
    chk("rson_respawn", 32'(respawn),      32'd1);

`ifdef ROUND_CTRL_EXTRA_LIFE_EN
    // Bonus life once per game.
    pass_ready();
    for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("bonus_lives", 32'(lives), 32'd4);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < DTH; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    pass_ready();
    for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("bonus_once", 32'(lives), 32'd3);
    chk("bonus_pel",  32'(pellets_left), 32'd44);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`endif

    // Random soak.
    for (int i = 0; i < 6000; i++) begin
      Reset = ($urandom_range(0, 1499) == 0);
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 59) == 0),
           1'($urandom_range(0, 999) == 0));
    end
    Reset = 1'b0;
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
